// File: rtl/lane_pulse_collector.sv
// Per-lane saturating pulse counters, drained round-robin as (lane, count, sat)
// records over a valid/ready interface. Counts taken out are subtracted, never cleared.
module lane_pulse_collector #(
  parameter int LANES  = 4,
  parameter int CNT_W  = 8,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  pulse_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [LANE_W:0]   LANES_V   = (LANE_W+1)'(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES-1);

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t            r_state;
  logic [LANE_W-1:0] r_ptr;

  logic [CNT_W-1:0]  w_cnt  [LANES];
  logic [LANES-1:0]  w_sat;
  logic [LANE_W:0]   w_dist [LANES];
  logic              w_handshake;

  assign w_handshake = out_valid && out_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LANE_W:0] LANE_IDX = (LANE_W+1)'(gi);

      logic [CNT_W-1:0] r_cnt;
      logic             r_sat;
      logic             w_take;
      logic [CNT_W-1:0] w_base;
      logic [CNT_W:0]   w_sum;

      // The snapshot is removed before this cycle's pulse is added.
      assign w_take = w_handshake && (out_lane == LANE_W'(gi));
      assign w_base = w_take ? (r_cnt - out_count) : r_cnt;
      assign w_sum  = {1'b0, w_base} + {{CNT_W{1'b0}}, pulse_i[gi]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_sat <= 1'b0;
        end else if (w_sum[CNT_W]) begin
          r_cnt <= CNT_MAX;
          r_sat <= 1'b1;
        end else begin
          r_cnt <= w_sum[CNT_W-1:0];
          if (w_take) begin
            r_sat <= 1'b0;
          end
        end
      end

      assign w_cnt[gi] = r_cnt;
      assign w_sat[gi] = r_sat;

      // Distance from the search pointer, wrapping at LANES (not a power of two in general).
      assign w_dist[gi] = (LANE_IDX >= {1'b0, r_ptr}) ? (LANE_IDX - {1'b0, r_ptr})
                                                      : (LANE_IDX + LANES_V - {1'b0, r_ptr});
    end
  endgenerate

  logic              w_found;
  logic [LANE_W-1:0] w_sel_lane;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic              w_sel_sat;
  logic [LANE_W:0]   w_best;

  // Non-zero lane closest to the pointer wins.
  always_comb begin
    w_found    = 1'b0;
    w_sel_lane = '0;
    w_sel_cnt  = '0;
    w_sel_sat  = 1'b0;
    w_best     = '0;
    for (int j = 0; j < LANES; j++) begin
      if ((w_cnt[j] != '0) && (!w_found || (w_dist[j] < w_best))) begin
        w_found    = 1'b1;
        w_sel_lane = LANE_W'(j);
        w_sel_cnt  = w_cnt[j];
        w_sel_sat  = w_sat[j];
        w_best     = w_dist[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            out_valid <= 1'b1;
            out_lane  <= w_sel_lane;
            out_count <= w_sel_cnt;
            out_sat   <= w_sel_sat;
            r_state   <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_ptr     <= (out_lane == LAST_LANE) ? '0 : out_lane + 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
